ushift_reg: RTL and testbench
=============================

# ushift_reg

Parametrised universal shift register, next generation of the team's 4-bit load/shift register. Adds configurable width, bidirectional logical/arithmetic shifts, rotates and clear. Adds a counted burst mode: one start command performs N consecutive shifts under a busy/done handshake. Used as the serialiser/deserialiser and bit-manipulation stage in the lab datapaths.

## Interface

Parameters:
- WIDTH, 8, register width; legal values ≥ 2.
- CNT_W, $clog2(WIDTH+1), burst count width (localparam, derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- op  in  3  operation code (see Operation).
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input entering the MSB on SHR.
- sin_r  in  1  serial input entering the LSB on SHL.
- start  in  1  request a burst of n repetitions of op.
- n  in  CNT_W  burst shift count.
- q  out  WIDTH  register contents.
- sout_l  out  1  equals q[WIDTH-1].
- sout_r  out  1  equals q[0].
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation

Op codes, shared by single-cycle and burst use:
- 000 NOP: hold.
- 001 LOAD: q <= d.
- 010 SHR: q <= {sin_l, q[WIDTH-1:1]}.
- 011 SHL: q <= {q[WIDTH-2:0], sin_r}.
- 100 ROR: q <= {q[0], q[WIDTH-1:1]}.
- 101 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
- 111 CLR: q <= 0.

States:
- IDLE:
  - start=1 with op in {SHR, SHL, ROR, ROL, ASR} and n ≥ 1: latch op and n into internal registers, no shift this edge, go to RUN.
  - start=1 with op in {SHR, SHL, ROR, ROL, ASR} and n = 0: no shift; done=1 next cycle; stay IDLE.
  - start=1 with op in {NOP, LOAD, CLR}: start is ignored and op executes as a normal single-cycle op.
  - start=0: op executes once per cycle.
- RUN:
  - One shift of the latched op per edge. Decrement the remaining count.
  - Inputs op, d, start and n are ignored.
  - sin_l and sin_r are sampled live on each shift edge.
  - On the edge performing the last shift: go to IDLE, busy <= 0, done <= 1.

Priority: rst > RUN activity > start acceptance > single-cycle op.

Reset:
- rst=1 at any edge, including mid-burst: q=0, state=IDLE, busy=0, done=0, internal count=0.

## Timing

- Single-cycle ops: q updates at the edge where op is sampled; latency 1.
- Burst accepted at edge t:
  - busy=1 after edges t through t+n-1, and 0 after edge t+n.
  - Shifts occur at edges t+1 … t+n.
  - done=1 for exactly the cycle after edge t+n.
  - Total latency n+1 cycles.
- n = 0: done=1 for the cycle after edge t; busy never asserts.
- done and busy are never high together.
- A new start is accepted in the cycle where done=1, since the state is IDLE by then.
- sout_l and sout_r are combinational from q; no extra latency.
- n larger than WIDTH is legal: shifting simply continues, so rotates wrap and shifts saturate to the fill pattern.

## Structure

- Shared header ushift_defs.vh holds:
  - localparams for the 8 op codes;
  - localparams for the state encodings (IDLE, RUN).
- Sub-module ushift_step:
  - combinational; inputs q, op, d, sin_l, sin_r; output next q.
  - instantiated once and fed with the live op when in IDLE, or the latched op when in RUN.
- Top level contains only the FSM, the counter, the q register and the done/busy flags.

## Test plan

All scenarios use WIDTH=8.
- Reset: drive rst=1 for one edge with q preloaded to 8'hFF and a burst in flight → q=8'h00, busy=0, done=0 after that edge.
- Single ops on q=8'hA5:
  - ROR → 8'hD2.
  - ROL (from 8'hA5) → 8'h4B.
  - CLR → 8'h00.
  - LOAD d=8'h3C → 8'h3C.
- Fill behaviour on q=8'h90:
  - ASR → 8'hC8.
  - SHR with sin_l=0 → 8'h48.
  - SHL with sin_r=1 → 8'h21.
  - sout_l and sout_r track q[7] and q[0].
- Burst: q=8'h81, op=ROL, n=3, start at edge t → busy high for 3 cycles, q=8'h0C after edge t+3, done pulses exactly one cycle, op toggled during RUN has no effect.
- Boundaries:
  - start with n=0 → done next cycle, q unchanged, busy stays 0.
  - ROR burst with n=8 on 8'h5A → q returns to 8'h5A.
  - back-to-back start issued during the done cycle is accepted.
- Abort: rst=1 during the second shift of an n=5 SHL burst → q=0, busy=0, and no done pulse afterwards.

Source files
------------

// File: rtl/ushift_reg_pkg.sv
// Shared op codes and FSM state encoding for the universal shift register.
// Also provides the helper that decides which ops may be issued as a burst.
package ushift_reg_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only the five shift/rotate ops can be repeated; NOP, LOAD and CLR are single-cycle.
  function automatic logic is_shift(input logic [2:0] o);
    return o inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR};
  endfunction

endpackage

// File: rtl/ushift_reg_step.sv
// Combinational next-value function of the register for a single op.
// Shared by single-cycle ops and by every repetition of a burst.
module ushift_reg_step
  import ushift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_LOAD: q_next = d;
      OP_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      OP_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLR:  q_next = '0;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/ushift_reg.sv
// Universal shift register with single-cycle ops and counted shift bursts.
// A burst latches op and count, then shifts once per cycle under busy/done.
module ushift_reg
  import ushift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_q;

  // During a burst the latched op drives the datapath; the live op is ignored.
  assign step_op = (state_reg == ST_RUN) ? op_reg : op;

  ushift_reg_step #(.WIDTH(WIDTH)) u_step (
    .q      (q_reg),
    .op     (step_op),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      q_reg     <= '0;
      cnt_reg   <= '0;
      op_reg    <= OP_NOP;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_RUN: begin
        q_next   = step_q;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        if (start && is_shift(op)) begin
          // Acceptance edge performs no shift; a zero count completes immediately.
          if (n != '0) begin
            op_next    = op;
            cnt_next   = n;
            state_next = ST_RUN;
            busy_next  = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end else begin
          q_next = step_q;
        end
      end
    endcase
  end

  assign q      = q_reg;
  assign sout_l = q_reg[WIDTH-1];
  assign sout_r = q_reg[0];
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_ushift_reg.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ushift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic             sin_l, sin_r, start;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] q;
  logic             sout_l, sout_r, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  ushift_reg #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .n      (n),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  // Reference model: a burst is a queue of pending shifts, one popped per cycle.
  logic [7:0] mq;
  bit         mbusy, mdone;
  logic [2:0] pend[$];

  function automatic logic [7:0] apply(input logic [2:0] o, input logic [7:0] v,
                                       input logic il, input logic ir, input logic [7:0] dv);
    case (o)
      3'd1:    return dv;
      3'd2:    return (v >> 1) | (il ? 8'h80 : 8'h00);
      3'd3:    return (v << 1) | (ir ? 8'h01 : 8'h00);
      3'd4:    return (v >> 1) | (v[0] ? 8'h80 : 8'h00);
      3'd5:    return (v << 1) | (v[7] ? 8'h01 : 8'h00);
      3'd6:    return (v >> 1) | (v & 8'h80);
      3'd7:    return 8'h00;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq = 8'h00;
      pend.delete();
      mdone = 1'b0;
    end else if (pend.size() > 0) begin
      mq = apply(pend.pop_front(), mq, sin_l, sin_r, d);
      mdone = (pend.size() == 0);
    end else if (start && (op >= 3'd2) && (op <= 3'd6)) begin
      for (int k = 0; k < int'(n); k++) pend.push_back(op);
      mdone = (n == 0);
    end else begin
      mq = apply(op, mq, sin_l, sin_r, d);
      mdone = 1'b0;
    end
    mbusy = (pend.size() > 0);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle{q,sl,sr,busy,done}", {20'd0, q, sout_l, sout_r, busy, done},
            {20'd0, mq, mq[7], mq[0], mbusy, mdone});
  end

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [7:0] exp);
    $display("[%0t] %s q=%h busy=%b done=%b", $time, name, q, busy, done);
    check(name, {24'd0, q}, {24'd0, exp});
    check({name, "_model"}, {24'd0, mq}, {24'd0, exp});
  endtask

  task automatic put(input logic [2:0] o, input logic [7:0] dv = 8'h00, input logic sl = 1'b0,
                     input logic sr = 1'b0, input logic st = 1'b0, input logic [3:0] nn = 4'd0);
    op = o; d = dv; sin_l = sl; sin_r = sr; start = st; n = nn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    put(3'd0);
    put(3'd0);
    cmp_en = 1'b1;
    rst = 1'b0;

    // Reset in the middle of a burst
    put(3'd1, 8'hFF);
    lit("load_ff", 8'hFF);
    put(3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
    put(3'd0);
    rst = 1'b1;
    put(3'd0);
    lit("reset_q", 8'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // Single ops
    put(3'd1, 8'hA5); put(3'd4); lit("ror_a5", 8'hD2);
    put(3'd1, 8'hA5); put(3'd5); lit("rol_a5", 8'h4B);
    put(3'd7); lit("clr", 8'h00);
    put(3'd1, 8'h3C); lit("load_3c", 8'h3C);

    // Fill behaviour
    put(3'd1, 8'h90);
    check("sout_l_90", {31'd0, sout_l}, 32'd1);
    check("sout_r_90", {31'd0, sout_r}, 32'd0);
    put(3'd6); lit("asr_90", 8'hC8);
    put(3'd1, 8'h90); put(3'd2, 8'h00, 1'b0); lit("shr_90", 8'h48);
    put(3'd1, 8'h90); put(3'd3, 8'h00, 1'b0, 1'b1); lit("shl_90", 8'h21);
    check("sout_l_21", {31'd0, sout_l}, 32'd0);
    check("sout_r_21", {31'd0, sout_r}, 32'd1);

    // ROL burst n=3 with op and start toggled while running
    put(3'd1, 8'h81);
    put(3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
    check("burst_busy_t", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      put(3'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b0, 1'($urandom), 4'd2);
      if (i < 2) check("burst_busy_run", {31'd0, busy}, 32'd1);
    end
    check("burst_busy_end", {31'd0, busy}, 32'd0);
    check("burst_done", {31'd0, done}, 32'd1);
    lit("burst_rol_81", 8'h0C);
    put(3'd0);
    check("burst_done_once", {31'd0, done}, 32'd0);

    // n = 0
    put(3'd1, 8'h5A);
    put(3'd2, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0);
    check("n0_done", {31'd0, done}, 32'd1);
    check("n0_busy", {31'd0, busy}, 32'd0);
    lit("n0_q", 8'h5A);
    put(3'd0);
    check("n0_done_once", {31'd0, done}, 32'd0);

    // Full rotation returns to start value
    put(3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8);
    repeat (7) put(3'd0);
    check("ror8_busy", {31'd0, busy}, 32'd1);
    put(3'd0);
    lit("ror8_q", 8'h5A);
    check("ror8_done", {31'd0, done}, 32'd1);

    // Back-to-back start during the done cycle
    put(3'd3, 8'h00, 1'b0, 1'b1, 1'b1, 4'd2);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    put(3'd0, 8'h00, 1'b0, 1'b1);
    lit("b2b_shift1", 8'hB5);
    put(3'd0, 8'h00, 1'b0, 1'b1);
    lit("b2b_shift2", 8'h6B);
    check("b2b_done", {31'd0, done}, 32'd1);

    // Abort an SHL burst during its second shift
    put(3'd1, 8'h0F);
    put(3'd3, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5);
    put(3'd0, 8'h00, 1'b0, 1'b1);
    lit("abort_shift1", 8'h1F);
    rst = 1'b1;
    put(3'd0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    lit("abort_q", 8'h00);
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      put(3'd0);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      op    = 3'($urandom_range(0, 7));
      d     = 8'($urandom);
      sin_l = 1'($urandom);
      sin_r = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      n     = 4'($urandom_range(0, 10));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    put(3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
